bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//   Consumes the two BCD digits produced by the binary-to-BCD stage (FirstDigit = tens,
//   SecondDigit = units) and drives a 2-digit common-anode multiplexed seven-segment display.
//   Latches digits on a load strobe and time-multiplexes the digit enables from a refresh counter.
//   Inserts a dead-time cycle at each digit switch and blanks a leading zero.
//   Sits between the BCD converter and the board's segment/digit pins.
// PARAMETERS
//   REFRESH_DIV    50000  clock cycles per digit slot; must be >= 2 (50 MHz -> 1 kHz per digit)
//   BLANK_LEADING  1      1: suppress the tens digit when it is 0; 0: always show it
//   CNT_W          localparam = $clog2(REFRESH_DIV); width of the slot counter
// PORTS
//   Clock        in   1  system clock; all state changes on the rising edge
//   Reset        in   1  synchronous, active-high; clears all state
//   Load         in   1  when high at a clock edge, FirstDigit/SecondDigit are latched
//   FirstDigit   in   4  tens BCD digit from the converter
//   SecondDigit  in   4  units BCD digit from the converter
//   Segments     out  7  {g,f,e,d,c,b,a}; active-low; registered
//   DigitEnable  out  2  [0] = units, [1] = tens; active-low; registered
// BEHAVIOUR
//   Reset: latched tens and units = 0, cnt = 0, sel = UNITS.
//     Segments = 7'b1111111 and DigitEnable = 2'b11 (all dark) on the edge Reset is sampled.
//     Reset takes priority over Load.
//   Slot counter cnt: counts 0..REFRESH_DIV-1.
//     At REFRESH_DIV-1, cnt wraps to 0 and sel toggles.
//   sel state machine has two states:
//     UNITS -> TENS on wrap; TENS -> UNITS on wrap. No other transitions.
//   Output registers sample f(cnt, sel, latched digits) each edge, so outputs lag state by 1 cycle.
//   Dead time: when cnt == 0, DigitEnable = 2'b11 and Segments = 7'b1111111.
//   Otherwise DigitEnable drives the selected digit low, and Segments = decode(selected digit).
//   Leading blank: if BLANK_LEADING = 1, sel = TENS and latched tens == 0:
//     DigitEnable = 2'b11 and Segments = 7'b1111111 for the whole slot.
//     A units 0 is never blanked.
//   Decode (active-low):
//     0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001,
//     5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
//     Codes 10-15 show a dash: 0111111.
//   Load latency: Load high at edge k latches both digits at edge k.
//     Segments reflect the new value at edge k+1 if that digit's slot is active; no waiting for slot end.
//     Load does not disturb cnt or sel.
//   Load held high: re-latches on every edge; inputs may change on every edge.
//   Reset mid-slot: cnt and sel return to 0/UNITS; the display is dark for the following cycle.
// STRUCTURE
//   Shared package seg7_pkg:
//     SEG_BLANK = 7'b1111111, SEG_DASH = 7'b0111111, DIG_OFF = 2'b11
//     typedef enum {UNITS, TENS} digit_sel_t
//   Sub-module bcd_to_seven_seg: combinational 4-bit BCD -> 7-bit active-low pattern, dash for 10-15.
//   Top level holds the latch, the slot counter, the sel FSM and the output registers.
// TESTING (bench uses REFRESH_DIV = 4)
//   1. Reset held 3 cycles, then released:
//      Segments = 1111111 and DigitEnable = 11 while in reset.
//      Next, units slot shows 0 (1000000, DigitEnable = 10) at cnt 1..3.
//      Tens slot is dark (blank leading).
//   2. Load with tens = 1, units = 5:
//      Units slot gives DigitEnable = 10, Segments = 0010010.
//      Tens slot gives DigitEnable = 01, Segments = 1111001.
//      Each slot starts with exactly 1 dark cycle.
//   3. Load with tens = 0, units = 7:
//      With BLANK_LEADING = 1, the tens slot is fully dark.
//      With BLANK_LEADING = 0, the tens slot shows 1000000.
//   4. Load with units = 4'hC:
//      The units slot shows a dash (0111111).
//   5. Load pulse mid units slot, changing units 3 -> 8:
//      Segments change to 0000000 at the next edge.
//      The slot boundary is unchanged (sel still toggles at the original wrap).
//   6. Reset asserted at cnt = 2 during the tens slot:
//      Outputs go dark at the next edge and digits clear to 0.
//      After release, scanning restarts from the units slot.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Purpose : Shared constants and types for the 2-digit seven-segment scanner.
//           All segment/digit patterns are active-low (common-anode display).
// Revision: 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Segment order is {g,f,e,d,c,b,a}; a 1 turns the segment off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Digit enables, [0] = units, [1] = tens; a 1 turns the digit off.
  localparam logic [1:0] DIG_OFF   = 2'b11;
  localparam logic [1:0] DIG_UNITS = 2'b10;
  localparam logic [1:0] DIG_TENS  = 2'b01;

  // Which digit currently owns the display slot.
  typedef enum logic {
    UNITS = 1'b0,
    TENS  = 1'b1
  } digit_sel_t;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seven_seg.sv
`default_nettype none
// ============================================================================
// Module  : bcd_to_seven_seg
// Purpose : Combinational BCD digit to active-low seven-segment pattern.
//           Non-decimal codes (10-15) render as a single middle dash.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_to_seven_seg
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pattern lookup; the default arm covers the invalid BCD codes.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module  : bcd_display_scanner
// Purpose : Latches a tens/units BCD pair and time-multiplexes it onto a
//           2-digit common-anode display, with one dark cycle at every slot
//           start and optional leading-zero suppression of the tens digit.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_display_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
)(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Load,
  input  logic [3:0] FirstDigit,
  input  logic [3:0] SecondDigit,
  output logic [6:0] Segments,
  output logic [1:0] DigitEnable
);

  localparam int               CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_sel_t       sel_q, sel_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       dig_en_q, dig_en_d;

  logic             cnt_wrap;
  logic [3:0]       cur_digit;
  logic [6:0]       cur_pattern;
  logic             tens_blanked;

  assign cnt_wrap     = (cnt_q == CNT_MAX);
  assign cur_digit    = (sel_q == TENS) ? tens_q : units_q;
  assign tens_blanked = BLANK_LEADING && (sel_q == TENS) && (tens_q == 4'd0);

  bcd_to_seven_seg u_decode (
    .bcd (cur_digit),
    .seg (cur_pattern)
  );

  // Digit latch and slot counter next-state; Load never touches the counter.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    cnt_d   = cnt_q + CNT_W'(1);
    if (Load) begin
      tens_d  = FirstDigit;
      units_d = SecondDigit;
    end
    if (cnt_wrap) begin
      cnt_d = '0;
    end
  end

  // Slot select FSM: alternates digits on every counter wrap.
  always_comb begin
    sel_d = sel_q;
    if (cnt_wrap) begin
      case (sel_q)
        UNITS:   sel_d = TENS;
        TENS:    sel_d = UNITS;
        default: sel_d = UNITS;
      endcase
    end
  end

  // Output pattern from current state; dark on the first cycle of each slot
  // so the previous digit's segments never ghost onto the newly enabled one.
  always_comb begin
    seg_d    = SEG_BLANK;
    dig_en_d = DIG_OFF;
    if ((cnt_q != '0) && !tens_blanked) begin
      seg_d    = cur_pattern;
      dig_en_d = (sel_q == TENS) ? DIG_TENS : DIG_UNITS;
    end
  end

  // State and output registers with synchronous reset to a dark display.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tens_q   <= 4'd0;
      units_q  <= 4'd0;
      cnt_q    <= '0;
      sel_q    <= UNITS;
      seg_q    <= SEG_BLANK;
      dig_en_q <= DIG_OFF;
    end else begin
      tens_q   <= tens_d;
      units_q  <= units_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign Segments    = seg_q;
  assign DigitEnable = dig_en_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_display_scanner
// Purpose : Directed self-checking bench for bcd_display_scanner with a
//           refresh divider of 4, covering both leading-blank settings.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

  localparam int DIV = 4;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] first_digit;
  logic [3:0] second_digit;
  logic [6:0] seg_b, seg_n;
  logic [1:0] de_b,  de_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: cycles since the last reset edge plus the latched digits.
  int m_n     = 0;
  int m_tens  = 0;
  int m_units = 0;

  logic [6:0] seg_tab [16];

  bcd_display_scanner #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) dut_b (
    .Clock       (clk),
    .Reset       (rst),
    .Load        (load),
    .FirstDigit  (first_digit),
    .SecondDigit (second_digit),
    .Segments    (seg_b),
    .DigitEnable (de_b)
  );

  bcd_display_scanner #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b0)) dut_n (
    .Clock       (clk),
    .Reset       (rst),
    .Load        (load),
    .FirstDigit  (first_digit),
    .SecondDigit (second_digit),
    .Segments    (seg_n),
    .DigitEnable (de_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Display content for the state that exists just before an edge.
  function automatic void expect_out(input int n, input bit r, input int tens,
                                     input int units, input bit blank,
                                     output logic [6:0] s, output logic [1:0] d);
    int phase;
    int slot;
    s = 7'b1111111;
    d = 2'b11;
    if (!r) begin
      phase = n % DIV;
      slot  = (n / DIV) % 2;
      if (phase != 0) begin
        if (slot == 0) begin
          s = seg_tab[units];
          d = 2'b10;
        end else if (!(blank && tens == 0)) begin
          s = seg_tab[tens];
          d = 2'b01;
        end
      end
    end
  endfunction

  // One clock: predict, let the edge happen, compare both DUTs, advance model.
  task automatic step();
    logic [6:0] es_b, es_n;
    logic [1:0] ed_b, ed_n;
    expect_out(m_n, rst, m_tens, m_units, 1'b1, es_b, ed_b);
    expect_out(m_n, rst, m_tens, m_units, 1'b0, es_n, ed_n);
    @(posedge clk);
    #1;
    chk("seg_blank1", seg_b, es_b);
    chk("de_blank1",  {5'b0, de_b}, {5'b0, ed_b});
    chk("seg_blank0", seg_n, es_n);
    chk("de_blank0",  {5'b0, de_n}, {5'b0, ed_n});
    if (rst) begin
      m_n = 0; m_tens = 0; m_units = 0;
    end else begin
      m_n++;
      if (load) begin
        m_tens  = int'(first_digit);
        m_units = int'(second_digit);
      end
    end
  endtask

  // Step until the next edge will sample the given slot (0 units, 1 tens) and phase.
  task automatic advance_to(input int s, input int p);
    for (int i = 0; i < 4 * DIV; i++) begin
      if (!rst && (m_n % DIV) == p && ((m_n / DIV) % 2) == s) return;
      step();
    end
    n_tests++;
    n_fail++;
    $display("FAIL advance_to: slot %0d phase %0d not reached", s, p);
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] u);
    load = 1'b1; first_digit = t; second_digit = u;
    step();
    load = 1'b0;
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;

    rst = 1'b1; load = 1'b0; first_digit = 4'd0; second_digit = 4'd0;
    #2;

    // 1. reset held three cycles, then release
    repeat (3) step();
    chk("lit_reset_seg", seg_b, 7'b1111111);
    chk("lit_reset_de",  {5'b0, de_b}, 7'd3);
    rst = 1'b0;
    step();
    chk("lit_first_dark", seg_b, 7'b1111111);
    step();
    chk("lit_units0_seg", seg_b, 7'b1000000);
    chk("lit_units0_de",  {5'b0, de_b}, 7'b0000010);
    advance_to(1, 1);
    step();
    chk("lit_tens_blank_de", {5'b0, de_b}, 7'd3);
    chk("lit_tens_noblank_seg", seg_n, 7'b1000000);

    // 2. tens 1, units 5
    do_load(4'd1, 4'd5);
    advance_to(0, 1);
    step();
    chk("lit_u5_seg", seg_b, 7'b0010010);
    chk("lit_u5_de",  {5'b0, de_b}, 7'b0000010);
    advance_to(1, 0);
    step();
    chk("lit_t1_dead", seg_b, 7'b1111111);
    step();
    chk("lit_t1_seg", seg_b, 7'b1111001);
    chk("lit_t1_de",  {5'b0, de_b}, 7'b0000001);

    // 3. tens 0, units 7
    do_load(4'd0, 4'd7);
    advance_to(1, 1);
    step();
    chk("lit_t0_blank_seg", seg_b, 7'b1111111);
    chk("lit_t0_show_seg",  seg_n, 7'b1000000);
    repeat (2 * DIV) step();

    // 4. invalid units code shows a dash
    do_load(4'd3, 4'hC);
    advance_to(0, 1);
    step();
    chk("lit_dash_seg", seg_b, 7'b0111111);

    // 5. mid-slot reload, units 3 -> 8
    do_load(4'd2, 4'd3);
    advance_to(0, 1);
    step();
    chk("lit_u3_seg", seg_b, 7'b0110000);
    load = 1'b1; second_digit = 4'd8;
    step();
    load = 1'b0;
    chk("lit_u3_still", seg_b, 7'b0110000);
    step();
    chk("lit_u8_seg", seg_b, 7'b0000000);
    step();
    chk("lit_wrap_dark", {5'b0, de_b}, 7'd3);
    step();
    chk("lit_t2_seg", seg_b, 7'b0100100);
    chk("lit_t2_de",  {5'b0, de_b}, 7'b0000001);

    // Load held high with digits changing every edge
    load = 1'b1;
    for (int i = 0; i < 3 * DIV; i++) begin
      first_digit  = 4'($urandom_range(0, 15));
      second_digit = 4'($urandom_range(0, 15));
      step();
    end
    load = 1'b0;
    repeat (2 * DIV) step();

    // 6. reset at cnt 2 of the tens slot
    do_load(4'd9, 4'd6);
    advance_to(1, 2);
    rst = 1'b1;
    step();
    chk("lit_midrst_seg", seg_b, 7'b1111111);
    chk("lit_midrst_de",  {5'b0, de_b}, 7'd3);
    rst = 1'b0;
    step();
    chk("lit_after_rst_dark", seg_b, 7'b1111111);
    step();
    chk("lit_after_rst_seg", seg_b, 7'b1000000);
    chk("lit_after_rst_de",  {5'b0, de_b}, 7'b0000010);
    repeat (2 * DIV) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
